// File: rtl/hist_y256.sv
// rtl/hist_y256.sv - 256-bin luma histogram with first-word-fall-through bin readout
//
// Purpose: pops 8-bit Y samples (din[7:0]) from the RGB-to-Y converter output,
// accumulates a 256-bin histogram over NUM_PIXELS samples, then presents the
// bin counts 0..255 on a FWFT read port. It then clears itself for the next frame.
//
// Ports:
//   clk        clock
//   srst       synchronous reset, active-high
//   din        input word, Y in [7:0], [31:8] ignored
//   wr_en      push din, accepted only while full=0
//   full       1 = input not accepted this cycle
//   dout       {bin_index[7:0], zero pad, count[BIN_W-1:0]}
//   rd_en      pop dout, honoured only while empty=0
//   empty      0 = dout holds a valid bin word
//   frame_done one-cycle pulse on the pop of bin 255
//
// Option: define HIST_SATURATE_EN to make bins saturate at 2^BIN_W-1 instead of wrapping.
module hist_y256 #(
  parameter int unsigned NUM_PIXELS = 76800,
  parameter int unsigned BIN_W      = 17
) (
  input  logic        clk,
  input  logic        srst,
  input  logic [31:0] din,
  input  logic        wr_en,
  output logic        full,
  output logic [31:0] dout,
  input  logic        rd_en,
  output logic        empty,
  output logic        frame_done
);

  typedef enum logic [1:0] {
    ST_CLEAR,
    ST_ACCUM,
    ST_DRAIN,
    ST_DUMP
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       idx_q, idx_d;     // clear index in CLEAR, displayed bin in DUMP
  logic [23:0]      pix_q, pix_d;
  logic             full_q, full_d;
  logic             valid_q, valid_d;

  // Increment pipeline: stage 1 holds the accepted sample while its bin is read,
  // the forward register holds the value written on the previous cycle.
  logic             s1_v_q;
  logic [7:0]       s1_y_q;
  logic             fw_v_q;
  logic [7:0]       fw_y_q;
  logic [BIN_W-1:0] fw_val_q;

  logic [BIN_W-1:0] mem [256];
  logic [BIN_W-1:0] rd_data_q;
  logic             ram_we;
  logic [7:0]       ram_waddr;
  logic [7:0]       ram_raddr;
  logic [BIN_W-1:0] ram_wdata;

  logic             accept;
  logic             pop;
  logic             last_px;
  logic [BIN_W-1:0] cur_cnt;
  logic [BIN_W-1:0] inc_cnt;
  logic             unused_din;

  function automatic logic [BIN_W-1:0] bump(input logic [BIN_W-1:0] v);
`ifdef HIST_SATURATE_EN
    return (&v) ? v : v + BIN_W'(1);
`else
    return v + BIN_W'(1);
`endif
  endfunction

  assign unused_din = ^din[31:8];

  // full_q is only ever 0 in ACCUM, so it alone gates acceptance.
  assign accept  = wr_en && !full_q;
  assign pop     = rd_en && valid_q;
  assign last_px = (pix_q == 24'(NUM_PIXELS - 1));

  // The RAM read issued alongside a sample lands on the same edge as the
  // previous sample's write, so it returns the stale count when both target
  // the same bin; take the just-written value instead. Two apart is already
  // committed by the time the read happens.
  assign cur_cnt = (fw_v_q && (fw_y_q == s1_y_q)) ? fw_val_q : rd_data_q;
  assign inc_cnt = bump(cur_cnt);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    pix_d     = pix_q;
    full_d    = full_q;
    valid_d   = valid_q;
    ram_we    = 1'b0;
    ram_waddr = s1_y_q;
    ram_wdata = inc_cnt;
    ram_raddr = din[7:0];

    case (state_q)
      ST_CLEAR: begin
        ram_we    = 1'b1;
        ram_waddr = idx_q;
        ram_wdata = '0;
        full_d    = 1'b1;
        valid_d   = 1'b0;
        pix_d     = '0;
        idx_d     = idx_q + 8'd1;
        if (idx_q == 8'd255) begin
          state_d = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        ram_we = s1_v_q;
        full_d = 1'b0;
        if (accept) begin
          pix_d = pix_q + 24'd1;
          if (last_px) begin
            full_d  = 1'b1;
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        // The final sample commits here; DUMP's first read follows it.
        ram_we  = s1_v_q;
        full_d  = 1'b1;
        idx_d   = 8'd0;
        state_d = ST_DUMP;
      end
      ST_DUMP: begin
        full_d  = 1'b1;
        valid_d = 1'b1;
        // Read address runs one ahead on a pop so the next bin is ready
        // on the following cycle without a bubble.
        ram_raddr = pop ? idx_q + 8'd1 : idx_q;
        if (pop) begin
          if (idx_q == 8'd255) begin
            state_d = ST_CLEAR;
            valid_d = 1'b0;
            idx_d   = 8'd0;
          end else begin
            idx_d = idx_q + 8'd1;
          end
        end
      end
      default: begin
        state_d = ST_CLEAR;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state_q <= ST_CLEAR;
      idx_q   <= 8'd0;
      pix_q   <= 24'd0;
      full_q  <= 1'b1;
      valid_q <= 1'b0;
      s1_v_q  <= 1'b0;
      fw_v_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pix_q   <= pix_d;
      full_q  <= full_d;
      valid_q <= valid_d;
      s1_v_q  <= accept;
      fw_v_q  <= s1_v_q;
    end
    s1_y_q   <= din[7:0];
    fw_y_q   <= s1_y_q;
    fw_val_q <= inc_cnt;
  end

  always_ff @(posedge clk) begin
    if (ram_we && !srst) begin
      mem[ram_waddr] <= ram_wdata;
    end
    rd_data_q <= mem[ram_raddr];
  end

  assign full       = full_q;
  assign empty      = !valid_q;
  assign frame_done = pop && (idx_q == 8'd255);
  assign dout       = valid_q ? {idx_q, 24'(rd_data_q)} : 32'd0;

endmodule

// File: tb/tb_hist_y256.sv
// tb/tb_hist_y256.sv - scoreboard bench for hist_y256 (main and narrow-bin instances)
module tb_hist_y256;

  logic        clk = 1'b0;
  logic        srst = 1'b1;
  logic [31:0] din_a = '0, din_b = '0;
  logic        wr_en_a = 1'b0, wr_en_b = 1'b0;
  logic        rd_en_a = 1'b0, rd_en_b = 1'b0;
  logic        full_a, full_b, empty_a, empty_b, fd_a, fd_b;
  logic [31:0] dout_a, dout_b;

  int          errors = 0;
  int          checks = 0;
  int          model [256];
  logic [31:0] exp_q [$];

  always #5 clk = ~clk;

  hist_y256 #(.NUM_PIXELS(256), .BIN_W(17)) u_dut (
    .clk(clk), .srst(srst), .din(din_a), .wr_en(wr_en_a), .full(full_a),
    .dout(dout_a), .rd_en(rd_en_a), .empty(empty_a), .frame_done(fd_a)
  );

  hist_y256 #(.NUM_PIXELS(20), .BIN_W(4)) u_ovf (
    .clk(clk), .srst(srst), .din(din_b), .wr_en(wr_en_b), .full(full_b),
    .dout(dout_b), .rd_en(rd_en_b), .empty(empty_b), .frame_done(fd_b)
  );

  function automatic logic f_full(input bit sel);
    return sel ? full_b : full_a;
  endfunction
  function automatic logic f_empty(input bit sel);
    return sel ? empty_b : empty_a;
  endfunction
  function automatic logic f_fd(input bit sel);
    return sel ? fd_b : fd_a;
  endfunction
  function automatic logic [31:0] f_dout(input bit sel);
    return sel ? dout_b : dout_a;
  endfunction

  task automatic set_wr(input bit sel, input logic en, input logic [7:0] y);
    if (sel) begin
      wr_en_b = en;
      din_b   = {24'($urandom()), y};
    end else begin
      wr_en_a = en;
      din_a   = {24'($urandom()), y};
    end
  endtask

  task automatic set_rd(input bit sel, input logic en);
    if (sel) rd_en_b = en;
    else     rd_en_a = en;
  endtask

  task automatic do_reset(output int n_edges, output bit bad, output logic [31:0] d0,
                          output logic f0, output logic e0);
    @(negedge clk);
    srst = 1'b1;
    set_wr(0, 1'b0, 8'd0);
    set_wr(1, 1'b0, 8'd0);
    set_rd(0, 1'b0);
    set_rd(1, 1'b0);
    @(negedge clk);
    d0 = dout_a;
    f0 = full_a;
    e0 = empty_a;
    srst = 1'b0;
    n_edges = 0;
    bad = 1'b0;
    while (n_edges < 400) begin
      @(negedge clk);
      n_edges++;
      if (empty_a !== 1'b1 || empty_b !== 1'b1 || fd_a !== 1'b0 || fd_b !== 1'b0) bad = 1'b1;
      if (full_a === 1'b0) break;
    end
    for (int k = 0; k < 256; k++) model[k] = 0;
    exp_q.delete();
  endtask

  task automatic send(input bit sel, input logic [7:0] y);
    int guard = 0;
    while (f_full(sel) && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (f_full(sel)) begin
      checks++;
      errors++;
      $display("FAIL send_wait: full=%0b after %0d cycles, required 0", f_full(sel), guard);
    end
    set_wr(sel, 1'b1, y);
    model[y]++;
    @(negedge clk);
    set_wr(sel, 1'b0, 8'd0);
  endtask

  task automatic push_expect(input bit sel);
    int w;
    int mx;
    int c;
    w  = sel ? 4 : 17;
    mx = (1 << w) - 1;
    for (int k = 0; k < 256; k++) begin
      c = model[k];
`ifdef HIST_SATURATE_EN
      if (c > mx) c = mx;
`else
      c = c & mx;
`endif
      exp_q.push_back({8'(k), 24'(c)});
      model[k] = 0;
    end
  endtask

  task automatic drain(input bit sel, input int stall_at);
    int          guard = 0;
    logic [31:0] exp_w;
    while (f_empty(sel) && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (guard > 4) begin
      errors++;
      $display("FAIL dump_latency: first word after %0d cycles, required <= 4", guard);
    end
    for (int k = 0; k < 256; k++) begin
      if (k == stall_at) begin
        set_rd(sel, 1'b0);
        set_wr(sel, 1'b1, 8'h33);
        for (int s = 0; s < 5; s++) begin
          @(negedge clk);
          checks++;
          if (f_dout(sel) !== exp_q[0] || f_empty(sel) !== 1'b0) begin
            errors++;
            $display("FAIL stall_hold: dout=%h empty=%0b, required %h empty=0",
                     f_dout(sel), f_empty(sel), exp_q[0]);
          end
        end
        set_wr(sel, 1'b0, 8'd0);
      end
      exp_w = exp_q.pop_front();
      set_rd(sel, 1'b1);
      #1;
      checks++;
      if (f_dout(sel) !== exp_w || f_empty(sel) !== 1'b0 || f_fd(sel) !== (k == 255)) begin
        errors++;
        $display("FAIL dump_word[%0d]: dout=%h empty=%0b frame_done=%0b, required %h empty=0 frame_done=%0b",
                 k, f_dout(sel), f_empty(sel), f_fd(sel), exp_w, (k == 255));
      end
      @(negedge clk);
    end
    set_rd(sel, 1'b0);
    checks++;
    if (f_empty(sel) !== 1'b1) begin
      errors++;
      $display("FAIL empty_after_last: empty=%0b, required 1", f_empty(sel));
    end
  endtask

  task automatic test_reset;
    int          n;
    bit          bad;
    logic [31:0] d0;
    logic        f0, e0;
    do_reset(n, bad, d0, f0, e0);
    checks++;
    if (d0 !== 32'd0 || f0 !== 1'b1 || e0 !== 1'b1) begin
      errors++;
      $display("FAIL reset_values: dout=%h full=%0b empty=%0b, required 0/1/1", d0, f0, e0);
    end
    checks++;
    if (n !== 257) begin
      errors++;
      $display("FAIL full_fall_edge: full fell after edge %0d, required 257", n);
    end
    checks++;
    if (full_b !== 1'b0) begin
      errors++;
      $display("FAIL ovf_full_fall: full=%0b, required 0", full_b);
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL clear_flags: empty/frame_done disturbed during clear, required empty=1 frame_done=0");
    end
  endtask

  task automatic test_ramp;
    for (int k = 0; k < 256; k++) send(0, 8'(k));
    checks++;
    if (full_a !== 1'b1) begin
      errors++;
      $display("FAIL full_after_last: full=%0b, required 1", full_a);
    end
    push_expect(0);
    drain(0, -1);
  endtask

  task automatic test_forwarding;
    logic [7:0] alt [6];
    alt = '{8'h81, 8'h80, 8'h81, 8'h80, 8'h81, 8'h80};
    for (int k = 0; k < 10; k++) send(0, 8'h80);
    for (int k = 0; k < 6; k++) send(0, alt[k]);
    for (int k = 0; k < 240; k++) send(0, 8'($urandom_range(0, 3)));
    push_expect(0);
    drain(0, -1);
  endtask

  task automatic test_stall;
    set_rd(0, 1'b1);
    for (int k = 0; k < 256; k++) send(0, 8'($urandom_range(0, 15)));
    set_rd(0, 1'b0);
    checks++;
    if (empty_a !== 1'b1) begin
      errors++;
      $display("FAIL rd_before_dump: empty=%0b, required 1", empty_a);
    end
    push_expect(0);
    drain(0, 7);
  endtask

  task automatic test_back_to_back;
    for (int k = 0; k < 256; k++) send(0, 8'($urandom_range(0, 255)));
    push_expect(0);
    drain(0, -1);
  endtask

  task automatic test_reset_mid_frame;
    int          n;
    bit          bad;
    logic [31:0] d0;
    logic        f0, e0;
    for (int k = 0; k < 100; k++) send(0, 8'($urandom_range(0, 255)));
    do_reset(n, bad, d0, f0, e0);
    checks++;
    if (n !== 257) begin
      errors++;
      $display("FAIL mid_reset_clear: full fell after edge %0d, required 257", n);
    end
    for (int k = 0; k < 256; k++) send(0, 8'd9);
    push_expect(0);
    drain(0, -1);
  endtask

  task automatic test_overflow;
    for (int k = 0; k < 20; k++) send(1, 8'd5);
    checks++;
    if (full_b !== 1'b1) begin
      errors++;
      $display("FAIL ovf_full_after_last: full=%0b, required 1", full_b);
    end
    push_expect(1);
    drain(1, -1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_ramp();
    test_forwarding();
    test_stall();
    test_back_to_back();
    test_reset_mid_frame();
    test_overflow();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
